// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: coin-started wash sequencer with built-in prescaled phase timers.
// Optional feature macro: WASH_PAUSE_EN adds timer_pause, which freezes SPINNING.
module wash_cycle_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int FILL_TICKS  = 60,
    parameter int WASH_TICKS  = 300,
    parameter int RINSE_TICKS = 60,
    parameter int SPIN_TICKS  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_in,
    input  logic       double_wash,
`ifdef WASH_PAUSE_EN
    input  logic       timer_pause,
`endif
    output logic [2:0] state,
    output logic       busy,
    output logic       phase_done,
    output logic       wash_done
);

    localparam int MAX_A     = (FILL_TICKS > WASH_TICKS) ? FILL_TICKS : WASH_TICKS;
    localparam int MAX_B     = (RINSE_TICKS > SPIN_TICKS) ? RINSE_TICKS : SPIN_TICKS;
    localparam int MAX_TICKS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4
    } state_t;

    state_t             r_state;
    logic [PRE_W-1:0]   r_presc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dbl;
    logic               r_pass;
    logic               r_busy;
    logic               r_phase_done;
    logic               r_wash_done;

    state_t             w_state_nxt;
    logic [PRE_W-1:0]   w_presc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_dbl_nxt;
    logic               w_pass_nxt;
    logic               w_wd_nxt;
    logic               w_pd_nxt;
    logic               w_enter;
    logic               w_tick;
    logic               w_end;
    logic               w_pause;

    function automatic logic [CNT_W-1:0] last_tick(input state_t s);
        case (s)
            ST_FILL:  last_tick = CNT_W'(FILL_TICKS - 1);
            ST_WASH:  last_tick = CNT_W'(WASH_TICKS - 1);
            ST_RINSE: last_tick = CNT_W'(RINSE_TICKS - 1);
            ST_SPIN:  last_tick = CNT_W'(SPIN_TICKS - 1);
            default:  last_tick = {CNT_W{1'b0}};
        endcase
    endfunction

    // Next-state, timer and flag logic for the sequencer
    always_comb begin
`ifdef WASH_PAUSE_EN
        w_pause = (r_state == ST_SPIN) && timer_pause;
`else
        w_pause = 1'b0;
`endif
        w_tick      = (r_presc == PRE_LAST);
        w_end       = w_tick && (r_cnt == last_tick(r_state)) && !w_pause;
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_cnt_nxt   = r_cnt;
        w_dbl_nxt   = r_dbl;
        w_pass_nxt  = r_pass;
        w_wd_nxt    = r_wash_done;
        w_enter     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (coin_in) begin
                    w_state_nxt = ST_FILL;
                    w_dbl_nxt   = double_wash;
                    w_pass_nxt  = 1'b0;
                    w_wd_nxt    = 1'b0;
                    w_enter     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_end) begin
                    w_state_nxt = ST_WASH;
                    w_enter     = 1'b1;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_WASH: begin
                if (w_end) begin
                    w_state_nxt = ST_RINSE;
                    w_enter     = 1'b1;
                end else begin
                    w_state_nxt = ST_WASH;
                end
            end
            ST_RINSE: begin
                // second pass skips the refill and goes straight back to washing
                if (w_end && r_dbl && !r_pass) begin
                    w_state_nxt = ST_WASH;
                    w_pass_nxt  = 1'b1;
                    w_enter     = 1'b1;
                end else if (w_end) begin
                    w_state_nxt = ST_SPIN;
                    w_enter     = 1'b1;
                end else begin
                    w_state_nxt = ST_RINSE;
                end
            end
            ST_SPIN: begin
                if (w_end) begin
                    w_state_nxt = ST_IDLE;
                    w_wd_nxt    = 1'b1;
                    w_enter     = 1'b1;
                end else begin
                    w_state_nxt = ST_SPIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_enter     = 1'b1;
            end
        endcase

        if (w_enter) begin
            w_presc_nxt = {PRE_W{1'b0}};
            w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (r_state != ST_IDLE && !w_pause) begin
            if (w_tick) begin
                w_presc_nxt = {PRE_W{1'b0}};
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end else begin
                w_presc_nxt = r_presc + PRE_W'(1);
            end
        end else begin
            w_presc_nxt = r_presc;
        end

        // phase_done is registered one cycle ahead so it lands on the final cycle
        w_pd_nxt = (w_state_nxt != ST_IDLE) && (w_presc_nxt == PRE_LAST) &&
                   (w_cnt_nxt == last_tick(w_state_nxt));
    end

    // State, timer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_presc      <= {PRE_W{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_dbl        <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b0;
            r_phase_done <= 1'b0;
            r_wash_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dbl        <= w_dbl_nxt;
            r_pass       <= w_pass_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_phase_done <= w_pd_nxt;
            r_wash_done  <= w_wd_nxt;
        end
    end

    assign state      = r_state;
    assign busy       = r_busy;
    assign phase_done = r_phase_done && !w_pause;
    assign wash_done  = r_wash_done;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed self-checking bench for wash_cycle_ctrl with shortened phase timers.
// Define WASH_PAUSE_EN to also exercise the SPIN pause feature.
module tb_wash_cycle_ctrl;

    localparam int TD = 4;
    localparam int FT = 2;
    localparam int WT = 3;
    localparam int RT = 2;
    localparam int SP = 1;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic       coin_in     = 1'b0;
    logic       double_wash = 1'b0;
`ifdef WASH_PAUSE_EN
    logic       timer_pause = 1'b0;
`endif
    logic [2:0] state;
    logic       busy;
    logic       phase_done;
    logic       wash_done;

    int   n_checks = 0;
    int   n_errs   = 0;
    int   dur[0:7];
    int   seq_st[0:7];
    int   nph;
    int   pulses;
    int   misalign;
    int   total;
    logic wd_at_idle;

    wash_cycle_ctrl #(
        .TICK_DIV   (TD),
        .FILL_TICKS (FT),
        .WASH_TICKS (WT),
        .RINSE_TICKS(RT),
        .SPIN_TICKS (SP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin_in    (coin_in),
        .double_wash(double_wash),
`ifdef WASH_PAUSE_EN
        .timer_pause(timer_pause),
`endif
        .state      (state),
        .busy       (busy),
        .phase_done (phase_done),
        .wash_done  (wash_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drives a coin now (just after an edge) and records every phase until IDLE returns.
    // mode 0: plain, 1: toggle coin/double_wash during WASH, 2: pause during WASH and mid-SPIN
    task automatic run_seq(input int mode, input logic dbl);
        logic [2:0] s;
        logic [2:0] prev;
        logic       prev_pd;
        bit         found;
`ifdef WASH_PAUSE_EN
        int         spin_seen;
        spin_seen = 0;
`endif
        nph = 0; pulses = 0; misalign = 0; total = -1; wd_at_idle = 1'b0;
        prev = 3'd0; prev_pd = 1'b0; found = 1'b0;
        coin_in = 1'b1;
        double_wash = dbl;
        for (int c = 1; c <= 200 && !found; c++) begin
            @(posedge clk);
            #1;
            s = state;
            if (c == 1) begin
                coin_in = 1'b0;
                double_wash = 1'b0;
            end
            if (c > 1 && ((s != prev) != prev_pd)) misalign++;
            pulses += int'(phase_done);
            if (s == 3'd0) begin
                found = 1'b1;
                total = c;
                wd_at_idle = wash_done;
            end else begin
                if (s != prev) begin
                    if (nph < 8) begin
                        seq_st[nph] = int'(s);
                        dur[nph] = 1;
                    end
                    nph++;
                end else if (nph >= 1 && nph <= 8) begin
                    dur[nph-1]++;
                end
                if (mode == 1) begin
                    coin_in     = (s == 3'd2) ? ~coin_in : 1'b0;
                    double_wash = (s == 3'd2);
                end
`ifdef WASH_PAUSE_EN
                if (s == 3'd4) spin_seen++;
                if (mode == 2) timer_pause = (s == 3'd2) || (s == 3'd4 && spin_seen >= 2 && spin_seen < 12);
`endif
            end
            prev = s;
            prev_pd = phase_done;
        end
        coin_in = 1'b0;
        double_wash = 1'b0;
`ifdef WASH_PAUSE_EN
        timer_pause = 1'b0;
`endif
    endtask

    task automatic check_run(input string tag, input logic dbl, input int spin_len, input int exp_total);
        int es[0:5];
        int ed[0:5];
        int n;
        es[0] = 1; ed[0] = FT * TD;
        es[1] = 2; ed[1] = WT * TD;
        es[2] = 3; ed[2] = RT * TD;
        n = 3;
        if (dbl) begin
            es[3] = 2; ed[3] = WT * TD;
            es[4] = 3; ed[4] = RT * TD;
            n = 5;
        end
        es[n] = 4; ed[n] = spin_len;
        n++;
        check_val({tag, "_total"}, total, exp_total);
        check_val({tag, "_phases"}, nph, n);
        check_val({tag, "_pulses"}, pulses, n);
        check_val({tag, "_pd_align"}, misalign, 0);
        check_val({tag, "_wd_at_idle"}, 32'(wd_at_idle), 1);
        for (int i = 0; i < n && i < nph; i++) begin
            check_val($sformatf("%s_state%0d", tag, i), seq_st[i], es[i]);
            check_val($sformatf("%s_len%0d", tag, i), dur[i], ed[i]);
        end
    endtask

    initial begin
        int bad;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_state", 32'(state), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_pd", 32'(phase_done), 0);
        check_val("rst_wd", 32'(wash_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("idle_after_rst", 32'(state), 0);

        run_seq(0, 1'b0);
        check_run("single", 1'b0, SP * TD, 33);

        run_seq(0, 1'b1);
        check_run("double", 1'b1, SP * TD, 53);

        run_seq(1, 1'b0);
        check_run("toggle", 1'b0, SP * TD, 33);

`ifdef WASH_PAUSE_EN
        run_seq(2, 1'b0);
        check_run("pause", 1'b0, 14, 43);
`endif

        coin_in = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            coin_in = 1'b0;
            if (state == 3'd3) break;
        end
        check_val("t4_in_rinse", 32'(state), 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("t4_state", 32'(state), 0);
        check_val("t4_busy", 32'(busy), 0);
        check_val("t4_wd", 32'(wash_done), 0);
        check_val("t4_pd", 32'(phase_done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("t4_idle_hold", 32'(state), 0);
        run_seq(0, 1'b0);
        check_run("after_rst", 1'b0, SP * TD, 33);

        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (wash_done !== 1'b1 || state !== 3'd0) bad++;
        end
        check_val("wd_hold_20", bad, 0);
        coin_in = 1'b1;
        @(posedge clk);
        #1;
        coin_in = 1'b0;
        check_val("wd_clear", 32'(wash_done), 0);
        check_val("coin_fill", 32'(state), 1);
        check_val("coin_busy", 32'(busy), 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
